// File: rtl/never8_pkg.sv
// never8_pkg
// Shared definitions for the 8-bit accumulator sequencer:
//   - ALU opcode constants driven onto alu_opcode
//   - instruction field positions ([7:5] opcode, [4:0] immediate)
//   - sequencer FSM state enum
// No ports; imported by the interface, core and testbench.
package never8_pkg;

  // ALU opcodes carried in instruction bits [7:5]
  localparam logic [2:0] OP_SOMA  = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOT   = 3'b101;
  localparam logic [2:0] OP_SHL   = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;

  // Instruction field positions
  localparam int INSTR_OP_MSB  = 7;
  localparam int INSTR_OP_LSB  = 5;
  localparam int INSTR_IMM_MSB = 4;
  localparam int INSTR_IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } seq_state_t;

  function automatic logic [2:0] instr_opcode(input logic [7:0] instr);
    return instr[INSTR_OP_MSB:INSTR_OP_LSB];
  endfunction

  function automatic logic [4:0] instr_imm(input logic [7:0] instr);
    return instr[INSTR_IMM_MSB:INSTR_IMM_LSB];
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
// Bundles every non-clock signal of the sequencer:
//   instruction input  : in_valid, in_ready, in_instr[7:0], in_skipz
//   accumulator load   : ld_en, ld_data[7:0]
//   external ALU       : alu_opcode[2:0], alu_a[4:0], alu_b[7:0] out;
//                        alu_data_out[7:0], alu_zflag, alu_c back in
//   result output      : out_valid, out_ready, out_data[7:0], out_z, out_c,
//                        out_skipped
//   status             : busy
// slave  = the sequencer core, master = the environment (ALU, producer, consumer).
interface alu_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_instr;
  logic       in_skipz;
  logic       ld_en;
  logic [7:0] ld_data;
  logic [2:0] alu_opcode;
  logic [4:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_data_out;
  logic       alu_zflag;
  logic       alu_c;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_z;
  logic       out_c;
  logic       out_skipped;
  logic       busy;

  modport slave (
    input  in_valid, in_instr, in_skipz, ld_en, ld_data,
    input  alu_data_out, alu_zflag, alu_c, out_ready,
    output in_ready, alu_opcode, alu_a, alu_b,
    output out_valid, out_data, out_z, out_c, out_skipped, busy
  );

  modport master (
    output in_valid, in_instr, in_skipz, ld_en, ld_data,
    output alu_data_out, alu_zflag, alu_c, out_ready,
    input  in_ready, alu_opcode, alu_a, alu_b,
    input  out_valid, out_data, out_z, out_c, out_skipped, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Sequences one 8-bit instruction at a time through an external ALU and keeps
// the accumulator plus Z/C flags.  IDLE -> ISSUE (ALU_SETTLE cycles) ->
// CAPTURE -> RESP, or IDLE -> RESP directly for a skipped conditional
// instruction (in_skipz with Z set).
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_sequencer_if.slave (instruction in, load, ALU, result out, busy)
// Parameters:
//   ACC_RESET  : accumulator value after reset
//   ALU_SETTLE : cycles (1..4) the ALU inputs are held before capture
module alu_sequencer
  import never8_pkg::*;
#(
  parameter logic [7:0] ACC_RESET  = 8'h00,
  parameter int         ALU_SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
);

  localparam logic [1:0] SETTLE_INIT = 2'(ALU_SETTLE - 1);

  seq_state_t state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] instr_q, instr_d;
  logic       skipped_q, skipped_d;
  // Copies of the ALU inputs from the most recent ISSUE, so the ALU keeps
  // seeing the last issued operation outside ISSUE, even across a skip.
  logic [2:0] hold_op_q, hold_op_d;
  logic [4:0] hold_a_q, hold_a_d;
  logic [7:0] hold_b_q, hold_b_d;

  // Next-state logic.  The ALU result is only looked at in CAPTURE, and the
  // load port only in IDLE when no instruction is being accepted.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    z_d       = z_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    skipped_d = skipped_q;
    hold_op_d = hold_op_q;
    hold_a_d  = hold_a_q;
    hold_b_d  = hold_b_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          instr_d = bus.in_instr;
          if (bus.in_skipz && z_q) begin
            skipped_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            skipped_d = 1'b0;
            cnt_d     = SETTLE_INIT;
            state_d   = ST_ISSUE;
          end
        end else if (bus.ld_en) begin
          acc_d = bus.ld_data;
        end
      end
      ST_ISSUE: begin
        hold_op_d = instr_opcode(instr_q);
        hold_a_d  = instr_imm(instr_q);
        hold_b_d  = acc_q;
        if (cnt_q == 2'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_CAPTURE: begin
        acc_d   = bus.alu_data_out;
        z_d     = bus.alu_zflag;
        c_d     = bus.alu_c;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= ACC_RESET;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      cnt_q     <= 2'd0;
      instr_q   <= 8'h00;
      skipped_q <= 1'b0;
      hold_op_q <= 3'd0;
      hold_a_q  <= 5'd0;
      hold_b_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      z_q       <= z_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      skipped_q <= skipped_d;
      hold_op_q <= hold_op_d;
      hold_a_q  <= hold_a_d;
      hold_b_q  <= hold_b_d;
    end
  end

  // ALU inputs come only from registers: the instruction register and the
  // accumulator during ISSUE (stable, since neither changes there), the held
  // copies elsewhere.
  always_comb begin
    if (state_q == ST_ISSUE) begin
      bus.alu_opcode = instr_opcode(instr_q);
      bus.alu_a      = instr_imm(instr_q);
      bus.alu_b      = acc_q;
    end else begin
      bus.alu_opcode = hold_op_q;
      bus.alu_a      = hold_a_q;
      bus.alu_b      = hold_b_q;
    end
  end

  // in_ready is masked by rst so nothing is offered during the reset cycle.
  assign bus.in_ready    = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid   = (state_q == ST_RESP);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.out_data    = acc_q;
  assign bus.out_z       = z_q;
  assign bus.out_c       = c_q;
  assign bus.out_skipped = skipped_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Directed bench for alu_sequencer: one instance with ALU_SETTLE=1 and
// ACC_RESET=8'h5A, one with ALU_SETTLE=3 and ACC_RESET=8'h00.  Each has a
// small behavioural ALU hanging off its interface.
module tb_alu_sequencer;
  import never8_pkg::*;

  logic clk;
  logic rst;
  int   total_count = 0;
  int   bad_count   = 0;

  alu_sequencer_if bus ();
  alu_sequencer_if bus3 ();

  alu_sequencer #(.ACC_RESET(8'h5A), .ALU_SETTLE(1)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  alu_sequencer #(.ACC_RESET(8'h00), .ALU_SETTLE(3)) u_dut3 (
    .clk(clk),
    .rst(rst),
    .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural external ALU: returns {carry, zero, result}.
  // SUB reports borrow on carry.
  function automatic logic [9:0] alu_model(input logic [2:0] op,
                                           input logic [4:0] a,
                                           input logic [7:0] b);
    logic [8:0] wide;
    case (op)
      OP_SOMA:  wide = {1'b0, b} + {4'b0, a};
      OP_SUB:   wide = {1'b0, b} - {4'b0, a};
      OP_AND:   wide = {1'b0, b & {3'b0, a}};
      OP_OR:    wide = {1'b0, b | {3'b0, a}};
      OP_XOR:   wide = {1'b0, b ^ {3'b0, a}};
      OP_NOT:   wide = {1'b0, ~b};
      OP_SHL:   wide = {b, 1'b0};
      default:  wide = {4'b0, a};
    endcase
    return {wide[8], (wide[7:0] == 8'h00), wide[7:0]};
  endfunction

  always_comb {bus.alu_c, bus.alu_zflag, bus.alu_data_out} =
      alu_model(bus.alu_opcode, bus.alu_a, bus.alu_b);
  always_comb {bus3.alu_c, bus3.alu_zflag, bus3.alu_data_out} =
      alu_model(bus3.alu_opcode, bus3.alu_a, bus3.alu_b);

  task automatic checkOutput(input string tag, input logic [7:0] got,
                             input logic [7:0] exp);
    total_count++;
    if (got !== exp) begin
      bad_count++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] instr, input logic skipz);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_skipz = skipz;
    tick();
    bus.in_valid = 1'b0;
    bus.in_skipz = 1'b0;
  endtask

  task automatic loadAcc(input logic [7:0] value);
    bus.ld_en   = 1'b1;
    bus.ld_data = value;
    tick();
    bus.ld_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0; bus.in_instr  = 8'h00; bus.in_skipz  = 1'b0;
    bus.ld_en     = 1'b0; bus.ld_data   = 8'h00; bus.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_instr = 8'h00; bus3.in_skipz = 1'b0;
    bus3.ld_en    = 1'b0; bus3.ld_data  = 8'h00; bus3.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();

    // Reset state, sampled while rst is still high
    checkOutput("rst_in_ready",  bus.in_ready,    8'h0);
    checkOutput("rst_busy",      bus.busy,        8'h0);
    checkOutput("rst_out_valid", bus.out_valid,   8'h0);
    checkOutput("rst_out_data",  bus.out_data,    8'h5A);
    checkOutput("rst_out_z",     bus.out_z,       8'h0);
    checkOutput("rst_out_c",     bus.out_c,       8'h0);
    checkOutput("rst_skipped",   bus.out_skipped, 8'h0);
    checkOutput("rst_dut3_data", bus3.out_data,   8'h00);
    rst = 1'b0;
    tick();
    checkOutput("idle_in_ready", bus.in_ready, 8'h1);

    // Load 01, add 1 -> 02; check cycle-by-cycle latency
    loadAcc(8'h01);
    checkOutput("load_data", bus.out_data, 8'h01);
    applyStimulus(8'h01, 1'b0);
    checkOutput("add_issue_busy",  bus.busy,       8'h1);
    checkOutput("add_issue_ready", bus.in_ready,   8'h0);
    checkOutput("add_issue_valid", bus.out_valid,  8'h0);
    checkOutput("add_alu_op",      bus.alu_opcode, 8'h0);
    checkOutput("add_alu_a",       bus.alu_a,      8'h01);
    checkOutput("add_alu_b",       bus.alu_b,      8'h01);
    tick();
    checkOutput("add_capt_valid", bus.out_valid, 8'h0);
    tick();
    checkOutput("add_resp_valid", bus.out_valid,   8'h1);
    checkOutput("add_data",       bus.out_data,    8'h02);
    checkOutput("add_z",          bus.out_z,       8'h0);
    checkOutput("add_c",          bus.out_c,       8'h0);
    checkOutput("add_skipped",    bus.out_skipped, 8'h0);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("add_done_valid", bus.out_valid, 8'h0);
    checkOutput("add_done_ready", bus.in_ready,  8'h1);

    // FF + 1 wraps to 00 with Z and C set
    loadAcc(8'hFF);
    applyStimulus(8'h01, 1'b0);
    tick();
    tick();
    checkOutput("wrap_valid", bus.out_valid, 8'h1);
    checkOutput("wrap_data",  bus.out_data,  8'h00);
    checkOutput("wrap_z",     bus.out_z,     8'h1);
    checkOutput("wrap_c",     bus.out_c,     8'h1);
    tick();
    checkOutput("wrap_idle", bus.busy, 8'h0);

    // Skipped instruction, then consumer stalls 5 cycles in RESP
    bus.out_ready = 1'b0;
    applyStimulus(8'h01, 1'b1);
    checkOutput("skip_valid",   bus.out_valid,   8'h1);
    checkOutput("skip_flag",    bus.out_skipped, 8'h1);
    checkOutput("skip_data",    bus.out_data,    8'h00);
    checkOutput("skip_z",       bus.out_z,       8'h1);
    checkOutput("skip_c",       bus.out_c,       8'h1);
    checkOutput("skip_alu_b",   bus.alu_b,       8'hFF);
    bus.ld_en    = 1'b1;
    bus.ld_data  = 8'hAA;
    bus.in_valid = 1'b1;
    bus.in_instr = 8'h65;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("stall%0d_valid", i), bus.out_valid,   8'h1);
      checkOutput($sformatf("stall%0d_data", i),  bus.out_data,    8'h00);
      checkOutput($sformatf("stall%0d_ready", i), bus.in_ready,    8'h0);
      checkOutput($sformatf("stall%0d_skip", i),  bus.out_skipped, 8'h1);
    end
    bus.ld_en     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checkOutput("stall_done_valid", bus.out_valid, 8'h0);
    checkOutput("stall_done_data",  bus.out_data,  8'h00);

    // ld_en together with in_valid: instruction wins (OR 5 on 00 -> 05)
    bus.ld_en   = 1'b1;
    bus.ld_data = 8'h33;
    applyStimulus(8'h65, 1'b0);
    bus.ld_en   = 1'b0;
    checkOutput("ldin_alu_op", bus.alu_opcode, 8'h3);
    checkOutput("ldin_alu_a",  bus.alu_a,      8'h05);
    checkOutput("ldin_alu_b",  bus.alu_b,      8'h00);
    tick();
    tick();
    checkOutput("ldin_valid",   bus.out_valid,   8'h1);
    checkOutput("ldin_data",    bus.out_data,    8'h05);
    checkOutput("ldin_z",       bus.out_z,       8'h0);
    checkOutput("ldin_c",       bus.out_c,       8'h0);
    checkOutput("ldin_skipped", bus.out_skipped, 8'h0);
    tick();

    // SUB 7 from 05 -> FE with borrow
    applyStimulus(8'h27, 1'b0);
    tick();
    tick();
    checkOutput("sub_data", bus.out_data, 8'hFE);
    checkOutput("sub_c",    bus.out_c,    8'h1);
    checkOutput("sub_z",    bus.out_z,    8'h0);
    tick();

    // Reset while in ISSUE aborts the instruction
    applyStimulus(8'h02, 1'b0);
    checkOutput("rstiss_busy_pre", bus.busy, 8'h1);
    rst = 1'b1;
    tick();
    checkOutput("rstiss_busy",  bus.busy,      8'h0);
    checkOutput("rstiss_valid", bus.out_valid, 8'h0);
    checkOutput("rstiss_data",  bus.out_data,  8'h5A);
    checkOutput("rstiss_z",     bus.out_z,     8'h0);
    checkOutput("rstiss_c",     bus.out_c,     8'h0);
    checkOutput("rstiss_ready", bus.in_ready,  8'h0);
    rst = 1'b0;
    tick();
    checkOutput("rstiss_ready_after", bus.in_ready, 8'h1);
    tick();
    checkOutput("rstiss_no_result", bus.out_valid, 8'h0);

    // Reset while RESP is waiting drops the result (XOR 1F on 5A -> 45)
    bus.out_ready = 1'b0;
    applyStimulus(8'h9F, 1'b0);
    tick();
    tick();
    checkOutput("xor_valid", bus.out_valid, 8'h1);
    checkOutput("xor_data",  bus.out_data,  8'h45);
    rst = 1'b1;
    tick();
    checkOutput("rstresp_valid", bus.out_valid, 8'h0);
    checkOutput("rstresp_data",  bus.out_data,  8'h5A);
    rst = 1'b0;
    tick();
    tick();
    checkOutput("rstresp_no_result", bus.out_valid, 8'h0);

    // ALU_SETTLE=3 instance: ALU inputs held 3 cycles, result 4 cycles on
    bus3.in_valid = 1'b1;
    bus3.in_instr = 8'h04;
    tick();
    bus3.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("s3_iss%0d_busy", i),  bus3.busy,       8'h1);
      checkOutput($sformatf("s3_iss%0d_valid", i), bus3.out_valid,  8'h0);
      checkOutput($sformatf("s3_iss%0d_op", i),    bus3.alu_opcode, 8'h0);
      checkOutput($sformatf("s3_iss%0d_a", i),     bus3.alu_a,      8'h04);
      checkOutput($sformatf("s3_iss%0d_b", i),     bus3.alu_b,      8'h00);
      tick();
    end
    checkOutput("s3_capt_valid", bus3.out_valid, 8'h0);
    tick();
    checkOutput("s3_resp_valid", bus3.out_valid, 8'h1);
    checkOutput("s3_resp_data",  bus3.out_data,  8'h04);
    bus3.out_ready = 1'b1;
    tick();
    checkOutput("s3_done_valid", bus3.out_valid, 8'h0);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter ACC_RESET, default 8'h00, value loaded into the accumulator on reset.
REQ-002 Parameter ALU_SETTLE, default 1, number of ISSUE cycles (1..4) that ALU ports are held stable before capture.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  sequencer can accept an instruction.
REQ-007 in_instr  input  8  instruction: [7:5] ALU opcode, [4:0] immediate operand.
REQ-008 in_skipz  input  1  conditional flag, sampled with in_instr: skip execution if Z flag set.
REQ-009 ld_en  input  1  load accumulator from ld_data.
REQ-010 ld_data  input  8  accumulator load value.
REQ-011 alu_opcode  output  3  to ALU opcode.
REQ-012 alu_a  output  5  to ALU a (immediate).
REQ-013 alu_b  output  8  to ALU b (accumulator).
REQ-014 alu_data_out  input  8  ALU result.
REQ-015 alu_zflag  input  1  ALU zero flag.
REQ-016 alu_c  input  1  ALU carry flag.
REQ-017 out_valid  output  1  result available.
REQ-018 out_ready  input  1  consumer accepts result.
REQ-019 out_data  output  8  accumulator value after instruction.
REQ-020 out_z, out_c  output  1 each  flag registers after instruction.
REQ-021 out_skipped  output  1  instruction was skipped, not executed.
REQ-022 busy  output  1  high in any state other than IDLE.

Function
REQ-023 FSM states IDLE, ISSUE, CAPTURE, RESP; IDLE is the reset state.
REQ-024 IDLE: in_ready=1; on in_valid, latch in_instr/in_skipz into the instruction register; go ISSUE, or RESP with out_skipped=1 when in_skipz=1 and Z register=1.
REQ-025 ISSUE: alu_opcode/alu_a from instruction register, alu_b from accumulator, held constant; stay ALU_SETTLE cycles (down-counter), then CAPTURE.
REQ-026 CAPTURE: accumulator<=alu_data_out, Z<=alu_zflag, C<=alu_c in one cycle; go RESP.
REQ-027 RESP: out_valid=1 with out_data/out_z/out_c/out_skipped stable until out_ready; on out_valid&out_ready go IDLE.
REQ-028 Latency, ALU_SETTLE=1, out_ready high: accept at edge E0, out_valid high in the cycle after E2, back in IDLE after E3; one instruction per 4 cycles.
REQ-029 Skipped instruction: accumulator and flags unchanged; out_valid high in the cycle after E0.
REQ-030 ld_en honoured only in IDLE: accumulator<=ld_data, flags unchanged; ignored in all other states.
REQ-031 ld_en and in_valid both high in IDLE: instruction accepted, load ignored.
REQ-032 Accumulator arithmetic is 8-bit wrap; carry reported only through C.
REQ-033 ALU outputs outside CAPTURE are never written to any register.
REQ-034 alu_* outputs hold the last issued values outside ISSUE; no combinational path from in_* to alu_*.

Reset
REQ-035 On rst: state IDLE, accumulator=ACC_RESET, Z=0, C=0, settle counter=0, instruction register=0, out_valid=0, out_skipped=0, busy=0, in_ready=0 during the rst cycle.
REQ-036 rst in any state, including RESP with out_valid high, aborts the instruction; no result is produced for it.

Structure
REQ-037 Package never8_pkg holds ALU opcode constants (OP_SOMA=3'b000 and siblings), instruction field positions, and the FSM state enum.
REQ-038 No sub-module; the ALU stays external and is connected at the core top level.

Verification
REQ-039 ld_en with ld_data=8'h01, then instr 8'b000_00001 -> out_data=8'h02, out_z=0, out_c=0, out_valid 2 cycles after accept.
REQ-040 Accumulator 8'hFF, instr 8'b000_00001 -> out_data=8'h00, out_z=1, out_c=1.
REQ-041 After REQ-040, instr with in_skipz=1 -> out_skipped=1, out_data=8'h00, out_valid in cycle after accept.
REQ-042 out_ready held low 5 cycles in RESP -> outputs stable, in_ready=0, ld_en ignored throughout.
REQ-043 rst asserted in ISSUE -> next cycle IDLE, out_data=ACC_RESET, out_z=0, out_c=0, out_valid=0.
REQ-044 ALU_SETTLE=3 -> alu_* stable for 3 cycles; out_valid 4 cycles after accept.
